// File: rtl/sine_filt.sv
// 17-tap symmetric half-sine low-pass FIR, one sample per clock.
// Pipeline: delay line -> pre-add/multiply -> adder tree -> output register.
module sine_filt #(
   parameter int DW    = 18,
   parameter int CW    = 18,
   parameter int NTAPS = 17
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [DW-1:0] x_in,
   output logic signed [DW-1:0] y
);

   localparam int NH = (NTAPS + 1) / 2;
   localparam int PW = DW + 1;
   localparam int MW = PW + CW;
   localparam int AW = 41;

   localparam logic signed [CW-1:0] H [NH] = '{
      18'sd1991, 18'sd3922, 18'sd5734, 18'sd7371, 18'sd8785,
      18'sd9931, 18'sd10776, 18'sd11293, 18'sd11466
   };

   logic signed [DW-1:0] d_q [NTAPS];
   logic signed [PW-1:0] pre [NH];
   logic signed [MW-1:0] p_d [NH];
   logic signed [MW-1:0] p_q [NH];
   logic signed [AW-1:0] acc_d;
   logic signed [AW-1:0] acc_q;
   logic signed [DW-1:0] y_q;
   logic                 unused_acc;

   // Symmetric taps share one multiplier; centre tap is used alone.
   always_comb begin
      for (int i = 0; i < NH; i++) begin
         pre[i] = '0;
         p_d[i] = '0;
      end
      for (int i = 0; i < NH - 1; i++) begin
         pre[i] = PW'(d_q[i]) + PW'(d_q[NTAPS-1-i]);
      end
      pre[NH-1] = PW'(d_q[NH-1]);
      for (int i = 0; i < NH; i++) begin
         p_d[i] = MW'(pre[i]) * MW'(H[i]);
      end
   end

   always_comb begin
      acc_d = '0;
      for (int i = 0; i < NH; i++) begin
         acc_d = acc_d + AW'(p_q[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NTAPS; i++) d_q[i] <= '0;
         for (int i = 0; i < NH; i++) p_q[i] <= '0;
         acc_q <= '0;
         y_q   <= '0;
      end else begin
         d_q[0] <= x_in;
         for (int i = 1; i < NTAPS; i++) d_q[i] <= d_q[i-1];
         for (int i = 0; i < NH; i++) p_q[i] <= p_d[i];
         acc_q <= acc_d;
         // Unity DC gain keeps the quotient inside 18 bits: no saturation.
         y_q   <= acc_q[34:17];
      end
   end

   assign unused_acc = ^{acc_q[AW-1:35], acc_q[16:0]};
   assign y          = y_q;

endmodule

// File: tb/tb_sine_filt.sv
// Bench for sine_filt: impulse table, reset, DC, ramp and random
// samples checked against a direct-convolution model.
module tb_sine_filt;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic signed [17:0]  x_in = '0;
   logic signed [17:0]  y;

   int total = 0;
   int bad = 0;

   int h [17] = '{1991, 3922, 5734, 7371, 8785, 9931, 10776, 11293,
                  11466, 11293, 10776, 9931, 8785, 7371, 5734, 3922, 1991};
   int imp_p [17] = '{995, 1961, 2867, 3685, 4392, 4965, 5388, 5646,
                      5733, 5646, 5388, 4965, 4392, 3685, 2867, 1961, 995};
   int imp_n [17] = '{-996, -1961, -2867, -3686, -4393, -4966, -5388,
                      -5647, -5733, -5647, -5388, -4966, -4393, -3686,
                      -2867, -1961, -996};

   typedef struct {
      logic signed [17:0] x;
      logic signed [17:0] y;
   } vec_t;

   vec_t   tbl [$];
   longint hist [$];

   always #5 clk = ~clk;

   sine_filt dut (
      .clk   (clk),
      .reset (reset),
      .x_in  (x_in),
      .y     (y)
   );

   task automatic chk(input string nm, input logic signed [17:0] act,
                      input logic signed [17:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic signed [17:0] model();
      longint s = 0;
      for (int k = 0; k < 17; k++) begin
         if (3 + k < hist.size()) s += longint'(h[k]) * hist[3+k];
      end
      return 18'(s >>> 17);
   endfunction

   task automatic step(input logic signed [17:0] x, input bit do_chk,
                       input string nm);
      x_in = x;
      @(posedge clk);
      #1;
      hist.push_front(longint'(x));
      if (hist.size() > 20) void'(hist.pop_back());
      if (do_chk) chk(nm, y, model());
   endtask

   task automatic hold_reset(input int n);
      reset = 1'b0;
      hist.delete();
      repeat (n) begin
         x_in = 18'($urandom);
         @(posedge clk);
         #1;
         chk("rst_hold", y, '0);
      end
      reset = 1'b1;
   endtask

   initial begin
      // reset held with toggling input
      hold_reset(21);

      // impulse table: positive then negative impulse
      tbl.push_back('{18'sd65536, 18'sd0});
      tbl.push_back('{18'sd0, 18'sd0});
      tbl.push_back('{18'sd0, 18'sd0});
      for (int k = 0; k < 17; k++) tbl.push_back('{18'sd0, 18'(imp_p[k])});
      tbl.push_back('{18'sd0, 18'sd0});
      tbl.push_back('{18'sd0, 18'sd0});
      tbl.push_back('{-18'sd65536, 18'sd0});
      tbl.push_back('{18'sd0, 18'sd0});
      tbl.push_back('{18'sd0, 18'sd0});
      for (int k = 0; k < 17; k++) tbl.push_back('{18'sd0, 18'(imp_n[k])});
      tbl.push_back('{18'sd0, 18'sd0});
      for (int i = 0; i < tbl.size(); i++) begin
         x_in = tbl[i].x;
         @(posedge clk);
         #1;
         chk($sformatf("table[%0d]", i), y, tbl[i].y);
      end

      // asynchronous reset mid-cycle
      hist.delete();
      for (int i = 0; i < 12; i++) step(18'sd50000, 1'b1, "pre_async");
      #3;
      reset = 1'b0;
      #1;
      chk("async_rst", y, '0);
      @(posedge clk);
      #1;
      hold_reset(2);

      // DC levels
      for (int i = 0; i < 25; i++) step(18'sd1000, 1'b1, "dc1000_m");
      chk("dc1000", y, 18'sd1000);
      hold_reset(2);
      for (int i = 0; i < 25; i++) step(-18'sd131072, 1'b1, "dcneg_m");
      chk("dc_min", y, -18'sd131072);
      hold_reset(2);
      for (int i = 0; i < 25; i++) step(18'sd131071, 1'b1, "dcmax_m");
      chk("dc_max", y, 18'sd131071);
      hold_reset(2);

      // ramp, reset pulse, fresh ramp
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 40; i++) begin
            step(18'(i), 1'b1, "ramp_m");
            if (i >= 19) chk($sformatf("ramp%0d", r), y, 18'(i - 11));
         end
         if (r == 0) begin
            reset = 1'b0;
            #1;
            chk("ramp_rst_now", y, '0);
            @(posedge clk);
            #1;
            chk("ramp_rst_edge", y, '0);
            reset = 1'b1;
            hist.delete();
         end
      end

      // random samples including extremes
      hold_reset(2);
      for (int i = 0; i < 10000; i++) begin
         logic signed [17:0] v;
         case (i % 97)
            0:       v = 18'sh1ffff;
            1:       v = 18'sh20000;
            default: v = 18'($urandom);
         endcase
         step(v, 1'b1, "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
